// File: rtl/next_pc_unit.sv
// Program-counter register with next-PC selection and a circular return-address stack.
// Optional BRANCH_STATS_EN adds a saturating 32-bit TakenCount output.
module next_pc_unit #(
   parameter int unsigned PC_W = 64,
   parameter int unsigned IMM_SHIFT = 2,
   parameter logic [PC_W-1:0] RESET_VECTOR = {PC_W{1'b0}},
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            CLK,
   input  logic            Reset_L,
   input  logic            Stall,
   input  logic            Branch,
   input  logic            BranchNZ,
   input  logic            ALUZero,
   input  logic            Uncondbranch,
   input  logic            Link,
   input  logic            IndirectBranch,
   input  logic            Return,
   input  logic [PC_W-1:0] SignExtImm,
   input  logic [PC_W-1:0] BranchReg,
   output logic [PC_W-1:0] CurrentPC,
   output logic [PC_W-1:0] NextPC,
   output logic            Taken,
   output logic            RasEmpty,
   output logic            RasFull
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     TakenCount
`endif
);

   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [PC_W-1:0] PC_STEP = PC_W'(3'd4);
   localparam logic [CNT_W-1:0] RAS_MAX = CNT_W'(RAS_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

   logic [PC_W-1:0]  pc_r;
   logic [PC_W-1:0]  ras_r [RAS_DEPTH];
   logic [PTR_W-1:0] top_r;
   logic [CNT_W-1:0] count_r;

   logic [PC_W-1:0]  seq_s;
   logic [PC_W-1:0]  rel_s;
   logic [PC_W-1:0]  imm_shifted_s;
   logic [PC_W-1:0]  next_pc_s;
   logic             taken_s;
   logic             cond_taken_s;
   logic             ras_empty_s;
   logic             ras_full_s;
   logic             push_s;
   logic             pop_s;
   logic [PTR_W-1:0] push_slot_s;

   assign imm_shifted_s = SignExtImm << IMM_SHIFT;
   assign seq_s         = pc_r + PC_STEP;
   assign rel_s         = pc_r + imm_shifted_s;
   assign cond_taken_s  = Uncondbranch | (Branch & (ALUZero ^ BranchNZ));
   assign ras_empty_s   = (count_r == {CNT_W{1'b0}});
   assign ras_full_s    = (count_r == RAS_MAX);
   // Return outranks Link, so a BL that is also a RET never pushes.
   assign push_s        = Link & Uncondbranch & ~Return & ~Stall;
   assign pop_s         = Return & ~Stall & ~ras_empty_s;
   assign push_slot_s   = top_r + PTR_ONE;

   // Target selection: Return > IndirectBranch > conditional/unconditional > sequential.
   always_comb begin
      next_pc_s = seq_s;
      taken_s   = 1'b0;
      if (Return) begin
         taken_s = 1'b1;
         if (!ras_empty_s) begin
            next_pc_s = ras_r[top_r];
         end else begin
            next_pc_s = BranchReg;
         end
      end else if (IndirectBranch) begin
         taken_s   = 1'b1;
         next_pc_s = BranchReg;
      end else if (cond_taken_s) begin
         taken_s   = 1'b1;
         next_pc_s = rel_s;
      end else begin
         taken_s   = 1'b0;
         next_pc_s = seq_s;
      end
   end

   // PC register; stall holds the current value.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         pc_r <= RESET_VECTOR;
      end else if (!Stall) begin
         pc_r <= next_pc_s;
      end
   end

   // Return-address stack; a push when full overwrites the oldest slot by wrapping.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         top_r   <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_r[i] <= {PC_W{1'b0}};
         end
      end else if (push_s) begin
         ras_r[push_slot_s] <= seq_s;
         top_r              <= push_slot_s;
         if (!ras_full_s) begin
            count_r <= count_r + CNT_ONE;
         end
      end else if (pop_s) begin
         top_r   <= top_r - PTR_ONE;
         count_r <= count_r - CNT_ONE;
      end
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] taken_count_r;

   // Saturating count of committed taken transfers.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         taken_count_r <= 32'h0000_0000;
      end else if (!Stall && taken_s && (taken_count_r != 32'hFFFF_FFFF)) begin
         taken_count_r <= taken_count_r + 32'h0000_0001;
      end
   end

   assign TakenCount = taken_count_r;
`endif

   assign CurrentPC = pc_r;
   assign NextPC    = next_pc_s;
   assign Taken     = taken_s;
   assign RasEmpty  = ras_empty_s;
   assign RasFull   = ras_full_s;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: stimulus queues hand-computed expectations,
// a monitor process pops and compares them against the DUT outputs.
module tb_next_pc_unit;

   logic        CLK = 1'b0;
   logic        Reset_L;
   logic        Stall, Branch, BranchNZ, ALUZero, Uncondbranch, Link;
   logic        IndirectBranch, Return;
   logic [63:0] SignExtImm, BranchReg;
   logic [63:0] CurrentPC, NextPC;
   logic        Taken, RasEmpty, RasFull;
`ifdef BRANCH_STATS_EN
   logic [31:0] TakenCount;
`endif

   typedef struct packed {
      int          tag;
      logic [63:0] pc;
      logic [63:0] npc;
      logic        tk;
      logic        emp;
      logic        full;
   } exp_t;

   exp_t exp_q[$];
   event sample_ev;
   int   checks = 0;
   int   errors = 0;
   int   tag_n  = 0;

   next_pc_unit #(.PC_W(64), .IMM_SHIFT(2), .RESET_VECTOR(64'h0), .RAS_DEPTH(4)) dut (
      .CLK(CLK), .Reset_L(Reset_L), .Stall(Stall), .Branch(Branch), .BranchNZ(BranchNZ),
      .ALUZero(ALUZero), .Uncondbranch(Uncondbranch), .Link(Link),
      .IndirectBranch(IndirectBranch), .Return(Return), .SignExtImm(SignExtImm),
      .BranchReg(BranchReg), .CurrentPC(CurrentPC), .NextPC(NextPC), .Taken(Taken),
      .RasEmpty(RasEmpty), .RasFull(RasFull)
`ifdef BRANCH_STATS_EN
      , .TakenCount(TakenCount)
`endif
   );

   always #5 CLK = ~CLK;

   // Monitor: one expectation is consumed per sample request.
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks += 5;
            if (CurrentPC !== e.pc) begin
               errors++;
               $display("FAIL chk%0d CurrentPC got %h want %h", e.tag, CurrentPC, e.pc);
            end
            if (NextPC !== e.npc) begin
               errors++;
               $display("FAIL chk%0d NextPC got %h want %h", e.tag, NextPC, e.npc);
            end
            if (Taken !== e.tk) begin
               errors++;
               $display("FAIL chk%0d Taken got %b want %b", e.tag, Taken, e.tk);
            end
            if (RasEmpty !== e.emp) begin
               errors++;
               $display("FAIL chk%0d RasEmpty got %b want %b", e.tag, RasEmpty, e.emp);
            end
            if (RasFull !== e.full) begin
               errors++;
               $display("FAIL chk%0d RasFull got %b want %b", e.tag, RasFull, e.full);
            end
         end
      end
   end

   task automatic expect_state(input logic [63:0] pc, input logic [63:0] npc,
                               input logic tk, input logic emp, input logic full);
      exp_t e;
      e.tag = tag_n; e.pc = pc; e.npc = npc; e.tk = tk; e.emp = emp; e.full = full;
      tag_n++;
      exp_q.push_back(e);
      -> sample_ev;
      #2;
   endtask

   task automatic idle();
      Stall = 1'b0; Branch = 1'b0; BranchNZ = 1'b0; ALUZero = 1'b0;
      Uncondbranch = 1'b0; Link = 1'b0; IndirectBranch = 1'b0; Return = 1'b0;
      SignExtImm = 64'h0; BranchReg = 64'h0;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [63:0] pc_exp;
      logic [63:0] ret_exp [5];
      ret_exp[0] = 64'h504; ret_exp[1] = 64'h404; ret_exp[2] = 64'h304;
      ret_exp[3] = 64'h204; ret_exp[4] = 64'h777;

      Reset_L = 1'b0;
      idle();
      #2;
      expect_state(64'h0, 64'h4, 1'b0, 1'b1, 1'b0);

      // Reach PC 0x40 through BR, then reset asynchronously mid-cycle.
      @(negedge CLK);
      Reset_L = 1'b1;
      IndirectBranch = 1'b1; BranchReg = 64'h40;
      #1;
      expect_state(64'h0, 64'h40, 1'b1, 1'b1, 1'b0);
      step();
      idle();
      expect_state(64'h40, 64'h44, 1'b0, 1'b1, 1'b0);
      Reset_L = 1'b0;
      expect_state(64'h0, 64'h4, 1'b0, 1'b1, 1'b0);

      // Sequential flow.
      @(negedge CLK);
      Reset_L = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         expect_state(64'(4 * i), 64'(4 * i + 4), 1'b0, 1'b1, 1'b0);
      end

      // CBZ / CBNZ at PC 0x10.
      Branch = 1'b1; ALUZero = 1'b1; BranchNZ = 1'b0; SignExtImm = 64'h2;
      expect_state(64'h10, 64'h18, 1'b1, 1'b1, 1'b0);
      BranchNZ = 1'b1;
      expect_state(64'h10, 64'h14, 1'b0, 1'b1, 1'b0);
      ALUZero = 1'b0;
      expect_state(64'h10, 64'h18, 1'b1, 1'b1, 1'b0);
      step();
      idle();
      expect_state(64'h18, 64'h1C, 1'b0, 1'b1, 1'b0);
      step();
      step();

      // Call / return at PC 0x20.
      Link = 1'b1; Uncondbranch = 1'b1; SignExtImm = 64'h40;
      expect_state(64'h20, 64'h120, 1'b1, 1'b1, 1'b0);
      step();
      idle();
      Return = 1'b1; BranchReg = 64'h999;
      expect_state(64'h120, 64'h24, 1'b1, 1'b0, 1'b0);
      step();
      idle();
      expect_state(64'h24, 64'h28, 1'b0, 1'b1, 1'b0);

      // RAS overflow: five BLs, each jumping 0x100 forward.
      IndirectBranch = 1'b1; BranchReg = 64'h100;
      step();
      idle();
      for (int k = 0; k < 5; k++) begin
         Link = 1'b1; Uncondbranch = 1'b1; SignExtImm = 64'h40;
         pc_exp = 64'(32'h100 * (k + 1));
         expect_state(pc_exp, pc_exp + 64'h100, 1'b1, (k == 0), (k >= 4));
         step();
      end
      idle();
      pc_exp = 64'h600;
      for (int j = 0; j < 5; j++) begin
         Return = 1'b1; BranchReg = 64'h777;
         expect_state(pc_exp, ret_exp[j], 1'b1, (j == 4), (j == 0));
         step();
         pc_exp = ret_exp[j];
      end
      idle();
      expect_state(64'h777, 64'h77B, 1'b0, 1'b1, 1'b0);

      // Stall holds PC and RAS while NextPC still shows the target.
      Stall = 1'b1; Branch = 1'b1; ALUZero = 1'b1; SignExtImm = 64'h2;
      for (int s = 0; s < 3; s++) begin
         expect_state(64'h777, 64'h77F, 1'b1, 1'b1, 1'b0);
         step();
      end
      Branch = 1'b0; ALUZero = 1'b0;
      Link = 1'b1; Uncondbranch = 1'b1; SignExtImm = 64'h10;
      for (int s = 0; s < 3; s++) begin
         expect_state(64'h777, 64'h7B7, 1'b1, 1'b1, 1'b0);
         step();
      end
      Stall = 1'b0;
      step();
      idle();
      expect_state(64'h7B7, 64'h7BB, 1'b0, 1'b0, 1'b0);

      // Return together with BL: Return wins and nothing is pushed.
      Return = 1'b1; Link = 1'b1; Uncondbranch = 1'b1; SignExtImm = 64'h10;
      expect_state(64'h7B7, 64'h77B, 1'b1, 1'b0, 1'b0);
      step();
      idle();
      expect_state(64'h77B, 64'h77F, 1'b0, 1'b1, 1'b0);

      // Indirect beats a taken conditional; Link alone is ignored.
      IndirectBranch = 1'b1; BranchReg = 64'h300; Branch = 1'b1; ALUZero = 1'b1;
      SignExtImm = 64'h2; Link = 1'b1;
      expect_state(64'h77B, 64'h300, 1'b1, 1'b1, 1'b0);
      step();
      idle();
      expect_state(64'h300, 64'h304, 1'b0, 1'b1, 1'b0);

      // Reset while stalled.
      Stall = 1'b1;
      Reset_L = 1'b0;
      expect_state(64'h0, 64'h4, 1'b0, 1'b1, 1'b0);

      for (int w = 0; w < 20 && exp_q.size() > 0; w++) #1;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain pending got %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
